// File: rtl/ir_feed.sv
// ir_feed: opcode/argument pair queue between instruction fetch and decode.
//
// A circular buffer of DEPTH {ir,k} pairs. The status unit can stall either
// side (hold_fetch, hold_decode), discard the queue (flush), or inject an
// opcode and/or argument in front of the queue head (replace_ir, replace_k).
// Injected pairs are presented to decode but never dequeue an entry.
//
// Ports:
//   clk, a_rst            clock, synchronous active-low reset
//   mem_valid/mem_ir/mem_k/mem_rdy   fetch side handshake
//   flush, hold_fetch, hold_decode   status unit controls
//   replace_ir/replace_k/int_ir/int_k   injection controls
//   dec_valid/dec_ir/dec_k/dec_rdy   decode side handshake
//   feed_ack              a pair was consumed this cycle
//   q_level               registered occupancy
module ir_feed #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       a_rst,
  input  logic                       mem_valid,
  input  logic [15:0]                mem_ir,
  input  logic [15:0]                mem_k,
  output logic                       mem_rdy,
  input  logic                       flush,
  input  logic                       hold_fetch,
  input  logic                       hold_decode,
  input  logic                       replace_ir,
  input  logic                       replace_k,
  input  logic [15:0]                int_ir,
  input  logic [15:0]                int_k,
  output logic                       dec_valid,
  output logic [15:0]                dec_ir,
  output logic [15:0]                dec_k,
  input  logic                       dec_rdy,
  output logic                       feed_ack,
  output logic [$clog2(DEPTH):0]     q_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] Full = (AW+1)'(DEPTH);

  logic [15:0]   ir_mem [DEPTH];
  logic [15:0]   k_mem  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  // Last head seen while non-empty; keeps outputs stable and defined when empty.
  logic [15:0]   last_ir_q, last_ir_d;
  logic [15:0]   last_k_q, last_k_d;

  logic          not_empty;
  logic          push;
  logic          pop;
  logic [15:0]   head_ir;
  logic [15:0]   head_k;

  assign not_empty = (count_q != '0);
  assign head_ir   = not_empty ? ir_mem[rd_ptr_q] : last_ir_q;
  assign head_k    = not_empty ? k_mem[rd_ptr_q]  : last_k_q;

  // Handshakes and output muxing.
  always_comb begin
    mem_rdy   = ~hold_fetch & (count_q != Full) & ~flush;
    push      = mem_valid & mem_rdy;
    dec_valid = replace_ir | (not_empty & ~hold_decode & ~flush);
    dec_ir    = replace_ir ? int_ir : head_ir;
    dec_k     = replace_k  ? int_k  : head_k;
    feed_ack  = dec_valid & dec_rdy;
    pop       = feed_ack & ~replace_ir;
  end

  assign q_level = count_q;

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_ir_d = last_ir_q;
    last_k_d  = last_k_q;
    if (not_empty) begin
      last_ir_d = head_ir;
      last_k_d  = head_k;
    end
    if (flush) begin
      // mem_rdy and dec_valid are already gated by flush, so no push/pop here.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_ir_q <= '0;
      last_k_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_ir_q <= last_ir_d;
      last_k_q  <= last_k_d;
    end
  end

  // Storage has no reset; a push during reset is dropped.
  always_ff @(posedge clk) begin
    if (push && a_rst) begin
      ir_mem[wr_ptr_q] <= mem_ir;
      k_mem[wr_ptr_q]  <= mem_k;
    end
  end

endmodule

// File: tb/tb_ir_feed.sv
module tb_ir_feed;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        a_rst;
  logic        mem_valid;
  logic [15:0] mem_ir;
  logic [15:0] mem_k;
  logic        mem_rdy;
  logic        flush;
  logic        hold_fetch;
  logic        hold_decode;
  logic        replace_ir;
  logic        replace_k;
  logic [15:0] int_ir;
  logic [15:0] int_k;
  logic        dec_valid;
  logic [15:0] dec_ir;
  logic [15:0] dec_k;
  logic        dec_rdy;
  logic        feed_ack;
  logic [2:0]  q_level;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a FIFO of {ir,k} words.
  logic [31:0] q[$];

  ir_feed #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .a_rst       (a_rst),
    .mem_valid   (mem_valid),
    .mem_ir      (mem_ir),
    .mem_k       (mem_k),
    .mem_rdy     (mem_rdy),
    .flush       (flush),
    .hold_fetch  (hold_fetch),
    .hold_decode (hold_decode),
    .replace_ir  (replace_ir),
    .replace_k   (replace_k),
    .int_ir      (int_ir),
    .int_k       (int_k),
    .dec_valid   (dec_valid),
    .dec_ir      (dec_ir),
    .dec_k       (dec_k),
    .dec_rdy     (dec_rdy),
    .feed_ack    (feed_ack),
    .q_level     (q_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then take the edge and update the model.
  task automatic cyc();
    int          sz;
    logic [31:0] hd;
    logic        rdy, vld, ack;
    #2;
    sz  = q.size();
    hd  = (sz != 0) ? q[0] : 32'h0;
    rdy = !hold_fetch && (sz != DEPTH) && !flush;
    vld = replace_ir || ((sz != 0) && !hold_decode && !flush);
    ack = vld && dec_rdy;
    chk("q_level", 32'(q_level), sz);
    chk("mem_rdy", 32'(mem_rdy), 32'(rdy));
    chk("dec_valid", 32'(dec_valid), 32'(vld));
    chk("feed_ack", 32'(feed_ack), 32'(ack));
    if (replace_ir) chk("dec_ir_inj", 32'(dec_ir), 32'(int_ir));
    else if (sz != 0) chk("dec_ir_head", 32'(dec_ir), 32'(hd[31:16]));
    if (replace_k) chk("dec_k_inj", 32'(dec_k), 32'(int_k));
    else if (sz != 0) chk("dec_k_head", 32'(dec_k), 32'(hd[15:0]));
    chk("dec_known", 32'($isunknown({dec_ir, dec_k})), 32'(0));
    @(posedge clk);
    if (!a_rst || flush) begin
      q.delete();
    end else begin
      if (ack && !replace_ir) void'(q.pop_front());
      if (mem_valid && rdy) q.push_back({mem_ir, mem_k});
    end
    #1;
  endtask

  task automatic offer(input logic [15:0] ir, input logic [15:0] k);
    mem_valid = 1'b1;
    mem_ir    = ir;
    mem_k     = k;
    cyc();
    mem_valid = 1'b0;
  endtask

  initial begin
    a_rst = 1'b0; mem_valid = 1'b0; mem_ir = '0; mem_k = '0;
    flush = 1'b0; hold_fetch = 1'b0; hold_decode = 1'b0;
    replace_ir = 1'b0; replace_k = 1'b0; int_ir = '0; int_k = '0; dec_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc();  // still in reset: q_level 0, mem_rdy follows hold/flush
    a_rst = 1'b1;

    // Single pair straight through.
    dec_rdy = 1'b1;
    offer(16'h1234, 16'h0042);
    chk("r038_level1", 32'(q_level), 32'd1);
    cyc();
    chk("r038_level0", 32'(q_level), 32'd0);

    // Fill, refuse a fifth, drain in order across the pointer wrap.
    dec_rdy = 1'b0;
    for (int i = 0; i < 4; i++) offer(16'hA000 + 16'(i), 16'hB000 + 16'(i));
    chk("r039_full", 32'(q_level), 32'd4);
    offer(16'hDEAD, 16'hBEEF);
    chk("r039_still_full", 32'(q_level), 32'd4);
    dec_rdy = 1'b1;
    repeat (4) cyc();
    chk("r039_drained", 32'(q_level), 32'd0);

    // Inject over two queued pairs.
    dec_rdy = 1'b0;
    offer(16'h1111, 16'h2222);
    offer(16'h3333, 16'h4444);
    replace_ir = 1'b1; replace_k = 1'b1; int_ir = 16'h832A; int_k = 16'hFFFC; dec_rdy = 1'b1;
    cyc();
    chk("r040_level", 32'(q_level), 32'd2);
    replace_ir = 1'b0; replace_k = 1'b0; dec_rdy = 1'b0;

    // Flush at level 3 with a push offered.
    offer(16'h5555, 16'h6666);
    chk("r041_level3", 32'(q_level), 32'd3);
    flush = 1'b1;
    offer(16'h7777, 16'h8888);
    flush = 1'b0;
    chk("r041_flushed", 32'(q_level), 32'd0);
    cyc();

    // Holds.
    offer(16'h0101, 16'h0202);
    offer(16'h0303, 16'h0404);
    hold_decode = 1'b1; dec_rdy = 1'b1;
    cyc();
    hold_fetch = 1'b1;
    offer(16'h0505, 16'h0606);
    chk("r042_level", 32'(q_level), 32'd2);
    hold_fetch = 1'b0; hold_decode = 1'b0;

    // Push and pop together, then reset mid-stream.
    offer(16'h0707, 16'h0808);
    chk("r043_level", 32'(q_level), 32'd2);
    cyc();
    dec_rdy = 1'b0;
    a_rst = 1'b0;
    offer(16'h0909, 16'h0A0A);
    a_rst = 1'b1;
    chk("r043_reset", 32'(q_level), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      mem_valid   = ($urandom_range(1, 0) == 1);
      mem_ir      = 16'($urandom);
      mem_k       = 16'($urandom);
      dec_rdy     = ($urandom_range(2, 0) != 0);
      hold_fetch  = ($urandom_range(4, 0) == 0);
      hold_decode = ($urandom_range(4, 0) == 0);
      replace_ir  = ($urandom_range(9, 0) == 0);
      replace_k   = ($urandom_range(7, 0) == 0);
      int_ir      = 16'($urandom);
      int_k       = 16'($urandom);
      flush       = ($urandom_range(24, 0) == 0);
      a_rst       = ($urandom_range(59, 0) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
